// File: rtl/id_fwd_stage.sv
// Instruction decode stage with operand forwarding, load-use stall control
// and a registered valid/ready output slot.
module id_fwd_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               pc_i,
  input  logic [31:0]               inst_i,
  output logic                      reg1_read_o,
  output logic                      reg2_read_o,
  output logic [4:0]                reg1_addr_o,
  output logic [4:0]                reg2_addr_o,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
  input  logic [NUM_FWD-1:0]        fwd_wreg_i,
  input  logic [5*NUM_FWD-1:0]      fwd_wd_i,
  input  logic [DATA_W*NUM_FWD-1:0] fwd_wdata_i,
  input  logic                      ex_load_i,
  input  logic                      flush_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                aluop_o,
  output logic [2:0]                alusel_o,
  output logic [DATA_W-1:0]         reg1_o,
  output logic [DATA_W-1:0]         reg2_o,
  output logic [4:0]                wd_o,
  output logic                      wreg_o,
  output logic [31:0]               pc_o,
  output logic                      inst_invalid_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);

  localparam logic [5:0] EXE_SPECIAL_INST = 6'b000000;
  localparam logic [5:0] EXE_AND  = 6'b100100;
  localparam logic [5:0] EXE_OR   = 6'b100101;
  localparam logic [5:0] EXE_XOR  = 6'b100110;
  localparam logic [5:0] EXE_NOR  = 6'b100111;
  localparam logic [5:0] EXE_ANDI = 6'b001100;
  localparam logic [5:0] EXE_ORI  = 6'b001101;
  localparam logic [5:0] EXE_XORI = 6'b001110;
  localparam logic [5:0] EXE_LUI  = 6'b001111;
  localparam logic [5:0] EXE_SLL  = 6'b000000;
  localparam logic [5:0] EXE_SLLV = 6'b000100;
  localparam logic [5:0] EXE_SRL  = 6'b000010;
  localparam logic [5:0] EXE_SRLV = 6'b000110;
  localparam logic [5:0] EXE_SRA  = 6'b000011;
  localparam logic [5:0] EXE_SRAV = 6'b000111;
  localparam logic [5:0] EXE_SYNC = 6'b001111;
  localparam logic [5:0] EXE_PREF = 6'b110011;
  localparam logic [5:0] EXE_LW   = 6'b100011;

  localparam logic [7:0] EXE_NOP_OP  = 8'b00000000;
  localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b01111100;
  localparam logic [7:0] EXE_SLLV_OP = 8'b00000100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b00000010;
  localparam logic [7:0] EXE_SRLV_OP = 8'b00000110;
  localparam logic [7:0] EXE_SRA_OP  = 8'b00000011;
  localparam logic [7:0] EXE_SRAV_OP = 8'b00000111;
  localparam logic [7:0] EXE_LW_OP   = 8'b11100011;

  localparam logic [2:0] EXE_RES_NOP        = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
  localparam logic [2:0] EXE_RES_LOAD_STORE = 3'b111;

  typedef enum logic {RUN, LDSTALL} state_t;

  state_t state_q, state_d;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, sa;

  logic [7:0]        aluop_d;
  logic [2:0]        alusel_d;
  logic [4:0]        wd_d;
  logic              wreg_d;
  logic              invalid_d;
  logic              r1_read, r2_read;
  logic [4:0]        r1_addr, r2_addr;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] op1, op2;

  logic              load_hazard;
  logic              accept;
  logic              out_valid_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  assign op    = inst_i[31:26];
  assign rs    = inst_i[25:21];
  assign rt    = inst_i[20:16];
  assign rd    = inst_i[15:11];
  assign sa    = inst_i[10:6];
  assign funct = inst_i[5:0];

  always_comb begin
    aluop_d   = EXE_NOP_OP;
    alusel_d  = EXE_RES_NOP;
    wd_d      = rd;
    wreg_d    = 1'b0;
    invalid_d = 1'b1;
    r1_read   = 1'b0;
    r2_read   = 1'b0;
    r1_addr   = rs;
    r2_addr   = rt;
    imm       = '0;

    if (op == EXE_SPECIAL_INST && sa == 5'd0) begin
      case (funct)
        EXE_OR, EXE_AND, EXE_XOR, EXE_NOR: begin
          wreg_d    = 1'b1;
          alusel_d  = EXE_RES_LOGIC;
          r1_read   = 1'b1;
          r2_read   = 1'b1;
          invalid_d = 1'b0;
          case (funct)
            EXE_OR:  aluop_d = EXE_OR_OP;
            EXE_AND: aluop_d = EXE_AND_OP;
            EXE_XOR: aluop_d = EXE_XOR_OP;
            default: aluop_d = EXE_NOR_OP;
          endcase
        end
        EXE_SLLV, EXE_SRLV, EXE_SRAV: begin
          wreg_d    = 1'b1;
          alusel_d  = EXE_RES_SHIFT;
          r1_read   = 1'b1;
          r2_read   = 1'b1;
          invalid_d = 1'b0;
          case (funct)
            EXE_SLLV: aluop_d = EXE_SLLV_OP;
            EXE_SRLV: aluop_d = EXE_SRLV_OP;
            default:  aluop_d = EXE_SRAV_OP;
          endcase
        end
        EXE_SYNC: begin
          r2_read   = 1'b1;
          invalid_d = 1'b0;
        end
        default: ;
      endcase
    end

    // Immediate shifts overlap the R-type space; they only decode with rs==0.
    if (inst_i[31:21] == 11'd0 &&
        (funct == EXE_SLL || funct == EXE_SRL || funct == EXE_SRA)) begin
      wreg_d    = 1'b1;
      alusel_d  = EXE_RES_SHIFT;
      r2_read   = 1'b1;
      imm[4:0]  = sa;
      invalid_d = 1'b0;
      case (funct)
        EXE_SLL: aluop_d = EXE_SLL_OP;
        EXE_SRL: aluop_d = EXE_SRL_OP;
        default: aluop_d = EXE_SRA_OP;
      endcase
    end

    case (op)
      EXE_ORI, EXE_ANDI, EXE_XORI: begin
        wreg_d     = 1'b1;
        wd_d       = rt;
        alusel_d   = EXE_RES_LOGIC;
        r1_read    = 1'b1;
        imm[15:0]  = inst_i[15:0];
        invalid_d  = 1'b0;
        case (op)
          EXE_ORI:  aluop_d = EXE_OR_OP;
          EXE_ANDI: aluop_d = EXE_AND_OP;
          default:  aluop_d = EXE_XOR_OP;
        endcase
      end
      EXE_LUI: begin
        wreg_d     = 1'b1;
        wd_d       = rt;
        aluop_d    = EXE_OR_OP;
        alusel_d   = EXE_RES_LOGIC;
        r1_read    = 1'b1;
        r1_addr    = 5'd0;
        imm[31:16] = inst_i[15:0];
        invalid_d  = 1'b0;
      end
      EXE_LW: begin
        wreg_d    = 1'b1;
        wd_d      = rt;
        aluop_d   = EXE_LW_OP;
        alusel_d  = EXE_RES_LOAD_STORE;
        r1_read   = 1'b1;
        imm       = {{(DATA_W-16){inst_i[15]}}, inst_i[15:0]};
        invalid_d = 1'b0;
      end
      EXE_PREF: invalid_d = 1'b0;
      default: ;
    endcase
  end

  function automatic logic [DATA_W-1:0] pick_operand(
    input logic              rd_en,
    input logic [4:0]        addr,
    input logic [DATA_W-1:0] rf_data,
    input logic [DATA_W-1:0] imm_v
  );
    logic              hit;
    logic [DATA_W-1:0] v;
    hit = 1'b0;
    v   = rf_data;
    if (!rd_en) begin
      v = imm_v;
    end else if (addr == 5'd0) begin
      v = '0;
    end else begin
      for (int unsigned i = 0; i < NUM_FWD; i++) begin
        if (!hit && fwd_wreg_i[i] && fwd_wd_i[i*5 +: 5] == addr) begin
          hit = 1'b1;
          v   = fwd_wdata_i[i*DATA_W +: DATA_W];
        end
      end
    end
    return v;
  endfunction

  always_comb begin
    op1 = pick_operand(r1_read, r1_addr, reg1_data_i, imm);
    op2 = pick_operand(r2_read, r2_addr, reg2_data_i, imm);
  end

  always_comb begin
    load_hazard = 1'b0;
    if (ex_load_i && fwd_wreg_i[0] && fwd_wd_i[4:0] != 5'd0)
      load_hazard = (r1_read && r1_addr == fwd_wd_i[4:0]) ||
                    (r2_read && r2_addr == fwd_wd_i[4:0]);
  end

  assign in_ready = !rst && !load_hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready && !flush_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (in_valid && load_hazard && !flush_i) state_d = LDSTALL;
      LDSTALL: if (flush_i || !load_hazard) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      aluop_o        <= EXE_NOP_OP;
      alusel_o       <= EXE_RES_NOP;
      reg1_o         <= '0;
      reg2_o         <= '0;
      wd_o           <= '0;
      wreg_o         <= 1'b0;
      pc_o           <= '0;
      inst_invalid_o <= 1'b0;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q    <= 1'b1;
      aluop_o        <= aluop_d;
      alusel_o       <= alusel_d;
      reg1_o         <= op1;
      reg2_o         <= op2;
      wd_o           <= wd_d;
      wreg_o         <= wreg_d;
      pc_o           <= pc_i;
      inst_invalid_o <= invalid_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (in_valid && load_hazard && !flush_i && !(&stall_cnt_q))
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
  end

  assign out_valid   = out_valid_q;
  assign stall_cnt_o = stall_cnt_q;
  assign reg1_read_o = r1_read;
  assign reg2_read_o = r2_read;
  assign reg1_addr_o = r1_addr;
  assign reg2_addr_o = r2_addr;

endmodule

// File: tb/tb_id_fwd_stage.sv
// Directed bench for id_fwd_stage: decode, forwarding, load-use stall,
// backpressure, flush, saturation and asynchronous reset.
module tb_id_fwd_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned NF = 3;
  localparam int unsigned CW = 3;

  logic          clk, rst;
  logic          in_valid, in_ready;
  logic [31:0]   pc_i, inst_i;
  logic          reg1_read_o, reg2_read_o;
  logic [4:0]    reg1_addr_o, reg2_addr_o;
  logic [DW-1:0] reg1_data_i, reg2_data_i;
  logic [NF-1:0] fwd_wreg_i;
  logic [5*NF-1:0]  fwd_wd_i;
  logic [DW*NF-1:0] fwd_wdata_i;
  logic          ex_load_i, flush_i;
  logic          out_valid, out_ready;
  logic [7:0]    aluop_o;
  logic [2:0]    alusel_o;
  logic [DW-1:0] reg1_o, reg2_o;
  logic [4:0]    wd_o;
  logic          wreg_o;
  logic [31:0]   pc_o;
  logic          inst_invalid_o;
  logic [CW-1:0] stall_cnt_o;

  logic [31:0] rf [32];
  int tests = 0;
  int fails = 0;

  id_fwd_stage #(.DATA_W(DW), .NUM_FWD(NF), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc_i(pc_i), .inst_i(inst_i),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
    .ex_load_i(ex_load_i), .flush_i(flush_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluop_o(aluop_o), .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .pc_o(pc_o),
    .inst_invalid_o(inst_invalid_o), .stall_cnt_o(stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    reg1_data_i = rf[reg1_addr_o];
    reg2_data_i = rf[reg2_addr_o];
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic en, input logic [4:0] wd, input logic [31:0] d);
    fwd_wreg_i[ch]         = en;
    fwd_wd_i[ch*5 +: 5]    = wd;
    fwd_wdata_i[ch*32 +: 32] = d;
  endtask

  task automatic clr_fwd();
    fwd_wreg_i  = '0;
    fwd_wd_i    = '0;
    fwd_wdata_i = '0;
    ex_load_i   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rst = 1'b1; in_valid = 1'b0; pc_i = '0; inst_i = '0;
    flush_i = 1'b0; out_ready = 1'b1;
    clr_fwd();
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_aluop", aluop_o, 0);
    check("rst_stall", stall_cnt_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // ori $1,$0,0x1100
    in_valid = 1'b1; pc_i = 32'h100; inst_i = 32'h34011100;
    #1 check("ori_in_ready", in_ready, 1);
    tick();
    check("ori_valid", out_valid, 1);
    check("ori_reg1", reg1_o, 32'h0);
    check("ori_reg2", reg2_o, 32'h00001100);
    check("ori_wd", wd_o, 1);
    check("ori_wreg", wreg_o, 1);
    check("ori_aluop", aluop_o, 8'h25);
    check("ori_alusel", alusel_o, 3'b001);
    check("ori_pc", pc_o, 32'h100);

    // $0 is never forwarded
    set_ch(0, 1'b1, 5'd0, 32'hFFFFFFFF);
    tick();
    check("zero_nofwd", reg1_o, 32'h0);

    // or $3,$1,$2 with forwarding priority
    rf[1] = 32'h0000DEAD; rf[2] = 32'h0000BEEF;
    set_ch(0, 1'b1, 5'd1, 32'hAAAA0000);
    set_ch(1, 1'b1, 5'd1, 32'h11111111);
    set_ch(2, 1'b1, 5'd2, 32'h00005555);
    pc_i = 32'h104; inst_i = 32'h00221825;
    tick();
    check("or_reg1", reg1_o, 32'hAAAA0000);
    check("or_reg2", reg2_o, 32'h00005555);
    check("or_wd", wd_o, 3);
    check("or_aluop", aluop_o, 8'h25);

    // sll $5,$2,3 from regfile
    clr_fwd();
    pc_i = 32'h108; inst_i = 32'h000228C0;
    #1 check("sll_reads", {reg1_read_o, reg2_read_o}, 2'b01);
    tick();
    check("sll_reg1", reg1_o, 3);
    check("sll_reg2", reg2_o, 32'h0000BEEF);
    check("sll_wd", wd_o, 5);
    check("sll_aluop", aluop_o, 8'h7C);
    check("sll_alusel", alusel_o, 3'b010);

    // lw $2,-16($1)
    pc_i = 32'h10C; inst_i = 32'h8C22FFF0;
    tick();
    check("lw_reg1", reg1_o, 32'h0000DEAD);
    check("lw_reg2", reg2_o, 32'hFFFFFFF0);
    check("lw_wd", wd_o, 2);
    check("lw_aluop", aluop_o, 8'hE3);
    check("lw_alusel", alusel_o, 3'b111);

    // load-use stall on $1 for two cycles
    ex_load_i = 1'b1; set_ch(0, 1'b1, 5'd1, 32'h0);
    pc_i = 32'h110; inst_i = 32'h00221825;
    #1 check("ld_in_ready0", in_ready, 0);
    tick();
    check("ld_valid1", out_valid, 0);
    check("ld_ready1", in_ready, 0);
    check("ld_state1", dut.state_q, 1);
    tick();
    check("ld_valid2", out_valid, 0);
    check("ld_stall2", stall_cnt_o, 2);
    clr_fwd(); set_ch(1, 1'b1, 5'd1, 32'h12345678);
    #1 check("ld_ready_clr", in_ready, 1);
    tick();
    check("ld_acc_valid", out_valid, 1);
    check("ld_acc_reg1", reg1_o, 32'h12345678);
    check("ld_acc_reg2", reg2_o, 32'h0000BEEF);
    check("ld_acc_pc", pc_o, 32'h110);
    check("ld_stall_keep", stall_cnt_o, 2);
    check("ld_state_run", dut.state_q, 0);

    // backpressure holds the output, then flush wins over accept
    clr_fwd(); out_ready = 1'b0;
    pc_i = 32'h200; inst_i = 32'h34011100;
    #1 check("bp_in_ready", in_ready, 0);
    tick();
    check("bp_valid", out_valid, 1);
    check("bp_hold_reg1", reg1_o, 32'h12345678);
    check("bp_hold_pc", pc_o, 32'h110);
    out_ready = 1'b1; flush_i = 1'b1;
    #1 check("fl_in_ready", in_ready, 1);
    tick();
    check("fl_valid", out_valid, 0);
    check("fl_pc_nochg", pc_o, 32'h110);
    flush_i = 1'b0;

    // flush during LDSTALL returns to RUN without counting
    ex_load_i = 1'b1; set_ch(0, 1'b1, 5'd2, 32'h0);
    pc_i = 32'h204; inst_i = 32'h00221825;
    tick();
    check("fls_state_ld", dut.state_q, 1);
    check("fls_stall3", stall_cnt_o, 3);
    flush_i = 1'b1;
    tick();
    check("fls_state_run", dut.state_q, 0);
    check("fls_stall_nochg", stall_cnt_o, 3);
    check("fls_valid", out_valid, 0);
    flush_i = 1'b0;

    // unrecognised instruction
    clr_fwd();
    pc_i = 32'h300; inst_i = 32'hFC000000;
    tick();
    check("inv_valid", out_valid, 1);
    check("inv_flag", inst_invalid_o, 1);
    check("inv_wreg", wreg_o, 0);
    check("inv_aluop", aluop_o, 0);
    check("inv_alusel", alusel_o, 0);

    // stall counter saturates at 7
    ex_load_i = 1'b1; set_ch(0, 1'b1, 5'd1, 32'h0);
    pc_i = 32'h304; inst_i = 32'h00221825;
    for (int i = 0; i < 4; i++) tick();
    check("sat_reach", stall_cnt_o, 7);
    tick(); tick();
    check("sat_hold", stall_cnt_o, 7);

    // asynchronous reset mid-stall
    #2 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_stall", stall_cnt_o, 0);
    check("arst_inv", inst_invalid_o, 0);
    check("arst_pc", pc_o, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_state", dut.state_q, 0);
    @(negedge clk);
    rst = 1'b0;
    clr_fwd();
    pc_i = 32'h400; inst_i = 32'h34011100;
    tick();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_pc", pc_o, 32'h400);
    in_valid = 1'b0;
    tick();
    check("drain_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
